// File: rtl/axis_rr_fifo_arbiter_pkg.sv
// Shared definitions for the AXI-Stream round-robin FIFO arbiter.
//   - arb_state_e    : arbiter FSM encoding (IDLE / XFER)
//   - clog2_f        : constant ceil(log2) helper for counter widths
//   - last_bit_pos   : position of the end-of-packet flag in a FIFO word
//                      ({last, data}, so the flag sits just above the data)
package axis_rr_fifo_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    function automatic int clog2_f(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                width = i + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

    function automatic int last_bit_pos(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/axis_rr_fifo_arbiter_rr_pick.sv
// Combinational rotating-priority encoder.
// Ports:
//   req        : per-port request vector
//   last_grant : index of the most recently served port
//   winner     : first requesting port searching upward from last_grant+1, wrapping
//   any_req    : at least one request bit is set
module rr_priority_pick #(
    parameter int N        = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [N-1:0]        req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [ID_WIDTH-1:0] winner,
    output logic                any_req
);

    logic                found;
    logic [ID_WIDTH-1:0] cand;

    // Walk the ports in rotated order and keep the first requester seen.
    always_comb begin
        winner  = {ID_WIDTH{1'b0}};
        found   = 1'b0;
        cand    = {ID_WIDTH{1'b0}};
        for (int k = 1; k <= N; k++) begin
            cand = ID_WIDTH'((int'(last_grant) + k) % N);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end else begin
                found  = found;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/axis_rr_fifo_arbiter.sv
// Packet-level round-robin arbiter sharing one FIFO write port among N
// AXI-Stream inputs. A granted port owns the FIFO until its packet ends
// (or is force-terminated after MAX_BEATS beats), so packets never interleave.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   s_tdata_in    : packed per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid_in   : per-port valid
//   s_last_in     : per-port end-of-packet
//   s_tready_out  : per-port ready (only the owner may be ready)
//   fifo_wr_en    : FIFO write strobe
//   fifo_wdata    : FIFO word {last, data}
//   fifo_full     : FIFO full, stalls the owner
//   grant_valid   : a port currently owns the FIFO
//   grant_id      : owning port index
//   trunc_err     : one-cycle pulse after a packet was force-terminated
module axis_rr_fifo_arbiter
    import axis_rr_fifo_arbiter_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 256,
    parameter int ID_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*DATA_WIDTH-1:0] s_tdata_in,
    input  logic [N-1:0]          s_tvalid_in,
    input  logic [N-1:0]          s_last_in,
    output logic [N-1:0]          s_tready_out,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH:0]   fifo_wdata,
    input  logic                  fifo_full,
    output logic                  grant_valid,
    output logic [ID_WIDTH-1:0]   grant_id,
    output logic                  trunc_err
);

    localparam int BEAT_W   = clog2_f(MAX_BEATS);
    localparam int LAST_BIT = last_bit_pos(DATA_WIDTH);

    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                grant_valid_q, grant_valid_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic                trunc_err_q, trunc_err_d;

    logic [ID_WIDTH-1:0]   winner;
    logic                  any_req;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  eff_last;
    logic                  accept;

    rr_priority_pick #(
        .N        (N),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req        (s_tvalid_in),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign sel_data = s_tdata_in[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    // The beat counter reaching MAX_BEATS-1 forces the end of the packet,
    // which is also why the counter never has to wrap.
    assign eff_last = s_last_in[grant_id_q] | (beat_cnt_q == BEAT_W'(MAX_BEATS - 1));
    assign accept   = s_tvalid_in[grant_id_q] & ~fifo_full;

    // Next-state, counter and write-port muxing for the arbiter FSM.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        trunc_err_d   = 1'b0;
        s_tready_out  = {N{1'b0}};
        fifo_wr_en    = 1'b0;
        fifo_wdata    = {(DATA_WIDTH + 1){1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_id_d    = winner;
                    grant_valid_d = 1'b1;
                    beat_cnt_d    = {BEAT_W{1'b0}};
                    state_d       = ST_XFER;
                end else begin
                    state_d       = ST_IDLE;
                end
            end
            ST_XFER: begin
                s_tready_out[grant_id_q]    = ~fifo_full;
                fifo_wr_en                  = accept;
                fifo_wdata[LAST_BIT]        = eff_last;
                fifo_wdata[DATA_WIDTH-1:0]  = sel_data;
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (eff_last) begin
                        last_grant_d  = grant_id_q;
                        grant_valid_d = 1'b0;
                        state_d       = ST_IDLE;
                        // Forced end: the source never flagged last on this beat.
                        trunc_err_d   = ~s_last_in[grant_id_q];
                    end else begin
                        state_d       = ST_XFER;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State, grant and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= ID_WIDTH'(N - 1);
            beat_cnt_q    <= {BEAT_W{1'b0}};
            grant_valid_q <= 1'b0;
            grant_id_q    <= {ID_WIDTH{1'b0}};
            trunc_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            beat_cnt_q    <= beat_cnt_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            trunc_err_q   <= trunc_err_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign trunc_err   = trunc_err_q;

endmodule

// File: tb/tb_axis_rr_fifo_arbiter.sv
// Scoreboard bench for axis_rr_fifo_arbiter (N=4, DATA_WIDTH=8, MAX_BEATS=4).
// A round loads packets on a set of ports at once; a reference model
// serves those packets round-robin (truncating at MAX_BEATS) and queues the
// expected FIFO words. A monitor pops and compares on every FIFO write.
module tb_axis_rr_fifo_arbiter;

    localparam int NP   = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;
    localparam int IDW  = 2;

    typedef struct {
        logic [DW:0] word;
        int          port;
        bit          forced;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*DW-1:0]  s_tdata_in = '0;
    logic [NP-1:0]     s_tvalid_in = '0;
    logic [NP-1:0]     s_last_in = '0;
    logic [NP-1:0]     s_tready_out;
    logic              fifo_wr_en;
    logic [DW:0]       fifo_wdata;
    logic              fifo_full = 1'b0;
    logic              grant_valid;
    logic [IDW-1:0]    grant_id;
    logic              trunc_err;

    int          checks = 0;
    int          fails  = 0;
    exp_t        exp_q[$];
    logic [DW:0] drv_q[NP][$];
    logic [NP-1:0] acc = '0;
    int          model_lg = NP - 1;
    bit          full_en = 1'b0;
    bit          bubble_en = 1'b0;
    bit          trunc_pend = 1'b0;
    bit          bubble_pend = 1'b0;
    exp_t        mon_e;

    axis_rr_fifo_arbiter #(
        .N(NP), .DATA_WIDTH(DW), .MAX_BEATS(MAXB), .ID_WIDTH(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tdata_in(s_tdata_in), .s_tvalid_in(s_tvalid_in), .s_last_in(s_last_in),
        .s_tready_out(s_tready_out),
        .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .grant_valid(grant_valid), .grant_id(grant_id), .trunc_err(trunc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Source drivers: present queued beats, random bubbles only while granted.
    always @(negedge clk) begin
        if (!rst) begin
            acc         = '0;
            s_tvalid_in = '0;
            s_last_in   = '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            end
            for (int i = 0; i < NP; i++) begin
                if (drv_q[i].size() > 0) begin
                    if (grant_valid && int'(grant_id) == i && bubble_en)
                        s_tvalid_in[i] = ($urandom_range(0, 3) != 0);
                    else
                        s_tvalid_in[i] = 1'b1;
                    s_tdata_in[i*DW +: DW] = drv_q[i][0][DW-1:0];
                    s_last_in[i]           = drv_q[i][0][DW];
                end else begin
                    s_tvalid_in[i]         = 1'b0;
                    s_last_in[i]           = 1'b0;
                    s_tdata_in[i*DW +: DW] = 8'($urandom);
                end
            end
            fifo_full = full_en && ($urandom_range(0, 3) == 0);
            #1;
            acc = s_tvalid_in & s_tready_out;
        end
    end

    // Monitor: compares every FIFO write and the cycle that follows it.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            trunc_pend  = 1'b0;
            bubble_pend = 1'b0;
        end else begin
            chk("trunc_err", 32'(trunc_err), 32'(trunc_pend));
            trunc_pend = 1'b0;
            if (bubble_pend) chk("bubble_wr_en", 32'(fifo_wr_en), 32'd0);
            bubble_pend = 1'b0;
            if (fifo_full) chk("stall_ready_wr", {27'd0, fifo_wr_en, s_tready_out}, 32'd0);
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_write actual=%0h expected=none t=%0t", fifo_wdata, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("fifo_wdata", 32'(fifo_wdata), 32'(mon_e.word));
                    chk("grant_id", 32'(grant_id), 32'(mon_e.port));
                    chk("grant_valid_on_write", 32'(grant_valid), 32'd1);
                    trunc_pend  = mon_e.forced;
                    bubble_pend = mon_e.word[DW];
                end
            end
        end
    end

    // Load packets and compute the expected FIFO stream with the reference model.
    task automatic issue_round(input int lens[NP], input bit fixed);
        logic [DW-1:0] data[NP][8];
        int rem[NP];
        int pos[NP];
        int total;
        int p_sel;
        int t;
        int b;
        exp_t e;
        total = 0;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < lens[p]; k++) begin
                data[p][k] = fixed ? 8'(8'hA1 + k) : 8'($urandom);
                drv_q[p].push_back({(k == lens[p] - 1), data[p][k]});
            end
            rem[p] = lens[p];
            pos[p] = 0;
            total += lens[p];
        end
        while (total > 0) begin
            p_sel = -1;
            for (int k = 1; k <= NP; k++) begin
                if (p_sel < 0 && rem[(model_lg + k) % NP] > 0) p_sel = (model_lg + k) % NP;
            end
            t = (rem[p_sel] < MAXB) ? rem[p_sel] : MAXB;
            for (int j = 0; j < t; j++) begin
                b        = pos[p_sel] + j;
                e.word   = {(j == t - 1), data[p_sel][b]};
                e.port   = p_sel;
                e.forced = (j == t - 1) && (b != lens[p_sel] - 1);
                exp_q.push_back(e);
            end
            pos[p_sel] += t;
            rem[p_sel] -= t;
            total      -= t;
            model_lg    = p_sel;
        end
    endtask

    function automatic bit all_drained();
        bit d;
        d = (exp_q.size() == 0) && !grant_valid;
        for (int i = 0; i < NP; i++) if (drv_q[i].size() != 0) d = 1'b0;
        return d;
    endfunction

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (!all_drained() && cyc < 600) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        chk("round_complete", 32'(all_drained()), 32'd1);
        if (!all_drained()) begin
            exp_q.delete();
            for (int i = 0; i < NP; i++) drv_q[i].delete();
        end
    endtask

    task automatic run_round(input int lens[NP], input bit fixed);
        @(posedge clk);
        #2;
        issue_round(lens, fixed);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_trunc_err"}, 32'(trunc_err), 32'd0);
        chk({tag, "_tready"}, 32'(s_tready_out), 32'd0);
        chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
        chk({tag, "_wdata"}, 32'(fifo_wdata), 32'd0);
    endtask

    initial begin
        int lens[NP];
        int cyc;
        rst = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Single port 1, 3 beats A1..A3.
        lens = '{0, 3, 0, 0};
        run_round(lens, 1'b1);
        // Contention on ports 0, 2, 3.
        lens = '{2, 0, 2, 2};
        run_round(lens, 1'b0);
        // Truncation: 6 beats with MAX_BEATS=4.
        lens = '{6, 0, 0, 0};
        run_round(lens, 1'b0);
        // Fairness wrap: port 3 served, then 0 and 3 compete.
        lens = '{0, 0, 0, 3};
        run_round(lens, 1'b0);
        lens = '{2, 0, 0, 2};
        run_round(lens, 1'b0);
        // Backpressure and source bubbles.
        full_en   = 1'b1;
        bubble_en = 1'b1;
        lens = '{0, 0, 4, 0};
        run_round(lens, 1'b0);
        for (int r = 0; r < 40; r++) begin
            for (int p = 0; p < NP; p++)
                lens[p] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 7));
            if (lens[0] + lens[1] + lens[2] + lens[3] == 0) lens[$urandom_range(0, 3)] = 2;
            run_round(lens, 1'b0);
        end

        // Reset in the middle of a packet.
        full_en   = 1'b0;
        bubble_en = 1'b0;
        @(posedge clk);
        #2;
        lens = '{0, 0, 3, 0};
        issue_round(lens, 1'b0);
        cyc = 0;
        while (exp_q.size() > 1 && cyc < 50) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        chk("pre_reset_grant_valid", 32'(grant_valid), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        for (int i = 0; i < NP; i++) drv_q[i].delete();
        model_lg = NP - 1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        lens = '{1, 1, 1, 1};
        run_round(lens, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
